// File: rtl/ps2_kbd_rx_if.sv
// MMIO-facing keyboard port of the PS/2 receiver: pop strobe in; FIFO status, head byte and error pulse out.
interface ps2_kbd_rx_if;
   logic       kbd_read_enable;
   logic       kbd_ready;
   logic [7:0] kbd_data;
   logic       kbd_overflow;
   logic       frame_err;

   // Handshake: kbd_ready is the valid flag for kbd_data. A one-cycle kbd_read_enable while
   // kbd_ready=1 consumes the head byte at that clock edge; a strobe while kbd_ready=0 is ignored.
   modport master (output kbd_read_enable, input kbd_ready, kbd_data, kbd_overflow, frame_err);
   modport slave  (input kbd_read_enable, output kbd_ready, kbd_data, kbd_overflow, frame_err);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the device clock, deserialises odd-parity
// frames and queues good scan-code bytes in a small FIFO drained by the MMIO block.
module ps2_kbd_rx #(
   parameter int DEPTH          = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   ps2_kbd_rx_if.slave kbd,
   output logic [1:0]  dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          fclk_q, fclk_d, fclk_prev_q;
   logic [FW-1:0] flt_cnt_q, flt_cnt_d;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    mem_q [DEPTH];
   logic          fall, push, empty, full, do_pop, do_push;

   // fclk only follows the synchronised clock once it has disagreed for FILTER_LEN samples in a row
   always_comb begin
      fclk_d    = fclk_q;
      flt_cnt_d = '0;
      if (clk_s2_q != fclk_q) begin
         if (flt_cnt_q == FW'(FILTER_LEN - 1)) fclk_d = clk_s2_q;
         else flt_cnt_d = flt_cnt_q + 1'b1;
      end
   end

   assign fall = fclk_prev_q & ~fclk_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      tmo_d     = '0;
      err_d     = 1'b0;
      push      = 1'b0;
      if (fall) begin
         case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shreg_d   = {dat_s2_q, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat_s2_q && (^{shreg_q, par_q})) push = 1'b1;
               else err_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         // A stalled device must not wedge the receiver mid-frame
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            shreg_d = '0;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = kbd.kbd_read_enable & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wptr_d = wptr_q + (do_push ? 1'b1 : 1'b0);
      rptr_d = rptr_q + (do_pop ? 1'b1 : 1'b0);
      ovf_d  = ovf_q;
      if (push && full && !do_pop) ovf_d = 1'b1;
      else if (do_pop) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         fclk_q      <= 1'b1;
         fclk_prev_q <= 1'b1;
         flt_cnt_q   <= '0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         clk_s1_q    <= ps2_clk;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= ps2_data;
         dat_s2_q    <= dat_s1_q;
         fclk_q      <= fclk_d;
         fclk_prev_q <= fclk_q;
         flt_cnt_q   <= flt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage needs no reset: an entry is only visible between its push and its pop
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= shreg_q;
   end

   assign kbd.kbd_ready    = ~empty;
   assign kbd.kbd_data     = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
   assign kbd.kbd_overflow = ovf_q;
   assign kbd.frame_err    = err_q;
   assign dbg_state        = state_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus random frames, checked every
// settled cycle against a byte-queue model of the keyboard FIFO.
module tb_ps2_kbd_rx;
   localparam int DEPTH = 8;
   localparam int FL    = 4;
   localparam int TMO   = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [1:0] dbg_state;

   ps2_kbd_rx_if kbd ();

   ps2_kbd_rx #(.DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .kbd       (kbd),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   bit         exp_ovf = 1'b0;
   int         exp_err = 0;
   int         err_cnt = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         settled = 1'b0;
   logic       err_prev = 1'b0;
   int         last_err_cyc = 0;
   int         last_fall_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (kbd.frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
            check("frame_err_single_cycle", {31'd0, err_prev}, 32'd0);
         end
         if (settled) begin
            check("kbd_ready", {31'd0, kbd.kbd_ready}, {31'd0, exp_q.size() != 0});
            check("kbd_data", {24'd0, kbd.kbd_data}, {24'd0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
            check("kbd_overflow", {31'd0, kbd.kbd_overflow}, {31'd0, exp_ovf});
         end
      end
      err_prev = kbd.frame_err;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(b);
   endtask

   task automatic pop();
      settled = 1'b0;
      kbd.kbd_read_enable = 1'b1;
      wait_cyc(1);
      kbd.kbd_read_enable = 1'b0;
      if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         exp_ovf = 1'b0;
      end
      settled = 1'b1;
   endtask

   // Device-side frame: data changes while the clock is high, the host samples on the fall.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int half, input int nbits, input bit glitch, input bit pop_at_stop);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      settled = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         wait_cyc(half);
         if (glitch && i == 5) begin
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(half);
         end
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         if (pop_at_stop && i == 10) begin
            // strobe lands on the cycle the stop-bit fall is detected (FL+2 edges after setup)
            wait_cyc(FL + 2);
            kbd.kbd_read_enable = 1'b1;
            wait_cyc(1);
            kbd.kbd_read_enable = 1'b0;
            wait_cyc(half - FL - 3);
         end else begin
            wait_cyc(half);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(half + FL + 8);
      if (nbits == 11) begin
         if (pop_at_stop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
         end
         if (!bad_par && !bad_stop) model_push(b);
         else exp_err++;
         check("frame_err_count", err_cnt, exp_err);
      end
      settled = 1'b1;
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 8, 11, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0, d;
      rst = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      kbd.kbd_read_enable = 1'b0;
      wait_cyc(4);
      check("rst_kbd_ready", {31'd0, kbd.kbd_ready}, 32'd0);
      check("rst_kbd_data", {24'd0, kbd.kbd_data}, 32'd0);
      check("rst_kbd_overflow", {31'd0, kbd.kbd_overflow}, 32'd0);
      check("rst_frame_err", {31'd0, kbd.frame_err}, 32'd0);
      check("rst_state_idle", {30'd0, dbg_state}, 32'd0);
      rst = 1'b1;
      wait_cyc(5);
      settled = 1'b1;

      // 0x1C good frame, then pop
      good(8'h1C);
      check("lit_1c_ready", {31'd0, kbd.kbd_ready}, 32'd1);
      check("lit_1c_data", {24'd0, kbd.kbd_data}, 32'h1C);
      pop();
      check("lit_pop_ready", {31'd0, kbd.kbd_ready}, 32'd0);
      check("lit_pop_data", {24'd0, kbd.kbd_data}, 32'd0);

      // parity error, then 0xF0
      send_frame(8'h1C, 1'b1, 1'b0, 8, 11, 1'b0, 1'b0);
      check("lit_parity_err_cnt", err_cnt, 32'd1);
      check("lit_parity_ready", {31'd0, kbd.kbd_ready}, 32'd0);
      good(8'hF0);
      check("lit_f0_data", {24'd0, kbd.kbd_data}, 32'hF0);
      pop();

      // a lone clock pulse with data high is not a start bit
      settled = 1'b0;
      e0 = err_cnt;
      ps2_clk = 1'b0;
      wait_cyc(10);
      ps2_clk = 1'b1;
      wait_cyc(20);
      settled = 1'b1;
      check("idle_one_no_err", err_cnt - e0, 32'd0);
      check("idle_one_state", {30'd0, dbg_state}, 32'd0);

      // overflow: nine frames into eight entries
      for (int i = 1; i <= 9; i++) good(8'(i));
      check("lit_ovf_set", {31'd0, kbd.kbd_overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check("lit_ovf_pop_data", {24'd0, kbd.kbd_data}, i);
         pop();
         if (i == 1) check("lit_ovf_cleared", {31'd0, kbd.kbd_overflow}, 32'd0);
      end
      check("lit_ovf_drained", {31'd0, kbd.kbd_ready}, 32'd0);

      // full FIFO: push coinciding with pop
      for (int i = 0; i < 8; i++) good(8'h10 + 8'(i));
      send_frame(8'h18, 1'b0, 1'b0, 10, 11, 1'b0, 1'b1);
      check("lit_full_pp_ovf", {31'd0, kbd.kbd_overflow}, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         check("lit_full_pp_data", {24'd0, kbd.kbd_data}, 32'h10 + i);
         pop();
      end
      check("lit_full_pp_empty", {31'd0, kbd.kbd_ready}, 32'd0);

      // timeout: start + 5 data bits then silence
      e0 = err_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 8, 6, 1'b0, 1'b0);
      for (int i = 0; i < TMO + 200 && err_cnt == e0; i++) wait_cyc(1);
      check("timeout_err_seen", err_cnt - e0, 32'd1);
      d = last_err_cyc - last_fall_cyc;
      check("timeout_delay_in_window", {31'd0, (d >= TMO) && (d <= TMO + FL + 6)}, 32'd1);
      check("timeout_state_idle", {30'd0, dbg_state}, 32'd0);
      exp_err++;
      good(8'h5A);
      check("lit_5a_data", {24'd0, kbd.kbd_data}, 32'h5A);
      pop();

      // 2-cycle glitch mid-frame
      send_frame(8'h3C, 1'b0, 1'b0, 8, 11, 1'b1, 1'b0);
      check("lit_glitch_data", {24'd0, kbd.kbd_data}, 32'h3C);
      pop();

      // reset mid-frame with a byte already queued
      good(8'h22);
      send_frame(8'h99, 1'b0, 1'b0, 8, 5, 1'b0, 1'b0);
      settled = 1'b0;
      rst = 1'b0;
      wait_cyc(3);
      check("midrst_ready", {31'd0, kbd.kbd_ready}, 32'd0);
      check("midrst_state", {30'd0, dbg_state}, 32'd0);
      rst = 1'b1;
      exp_q.delete();
      exp_ovf = 1'b0;
      wait_cyc(5);
      settled = 1'b1;
      good(8'h76);
      check("lit_76_data", {24'd0, kbd.kbd_data}, 32'h76);
      pop();
      check("lit_76_only", {31'd0, kbd.kbd_ready}, 32'd0);

      // random frames with random pops
      for (int n = 0; n < 40; n++) begin
         send_frame(8'($urandom_range(255)), $urandom_range(7) == 0, $urandom_range(7) == 0,
                    $urandom_range(FL + 9, FL + 3), 11, 1'b0, 1'b0);
         for (int p = $urandom_range(1); p > 0; p--) pop();
         wait_cyc($urandom_range(15));
      end
      while (exp_q.size() != 0) pop();
      pop();
      check("final_err_count", err_cnt, exp_err);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver that produces the keyboard-side signals consumed by the memory-mapped I/O block: `kbd_ready`, `kbd_data`, `kbd_overflow`. It deserialises device-clocked PS/2 frames and checks framing and parity. Valid scan-code bytes go into a small FIFO that the CPU drains through `kbd_read_enable`. It sits between the board PS/2 pins and the MMIO keyboard port.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 4: consecutive equal synchronised samples required before filtered `ps2_clk` changes.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a filtered falling edge before an incomplete frame is abandoned.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pin; asynchronous.
- `kbd_read_enable`  in  1  one-cycle pop request from MMIO.
- `kbd_ready`  out  1  FIFO not empty.
- `kbd_data`  out  8  FIFO head byte; 0 when empty.
- `kbd_overflow`  out  1  sticky flag: a valid byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse on parity error, bad stop bit, or timeout.

## Operation
- Input synchronisation and filtering:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - Filtered clock `fclk` takes the synchronised clock value after `FILTER_LEN` consecutive identical samples.
  - A fall edge is the cycle where `fclk` registered 1 changes to 0.
  - On a fall edge, the synchronised `ps2_data` is the sampled bit.
- Frame format: start 0, eight data bits LSB first, odd parity bit, stop 1. Parity is valid when data bits plus parity bit contain an odd number of ones.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall edge, bit 0 → DATA with bit count 0. Bit 1 → stay in IDLE; no error.
  - DATA: on fall edge, shift the bit into `shreg[7]` with a right shift. After the 8th bit → PARITY.
  - PARITY: on fall edge, latch the parity bit → STOP.
  - STOP: on fall edge → IDLE.
    - Stop bit 1 and parity good: push `shreg` into the FIFO.
    - Otherwise: discard the byte and pulse `frame_err`.
- Timeout:
  - The counter clears on every fall edge and on IDLE.
  - In any non-IDLE state it increments each cycle.
  - On reaching `TIMEOUT_CYCLES`: go to IDLE, discard partial data, pulse `frame_err`.
- FIFO:
  - Read/write pointers are log2(`DEPTH`)+1 bits.
  - Full: pointers differ only in the MSB. Empty: pointers equal.
  - Pop occurs on `kbd_read_enable`=1 when not empty. Pop on empty is ignored.
  - Push with FIFO full and no same-cycle pop: byte dropped, `kbd_overflow` set.
  - Push and pop in the same cycle, including when full: both occur, count unchanged, no overflow.
  - `kbd_overflow` clears on reset or on any accepted pop; a same-cycle set takes priority over the clear.
- `kbd_data` = `mem[rptr]` when not empty, else 0. `kbd_ready` = not empty. Both are registered or derived from registered pointers; no combinational path from `kbd_read_enable`.

## Timing
- Reset: while `rst`=0, all state clears asynchronously.
  - FSM = IDLE; pointers = 0; `shreg` and timeout counter = 0.
  - Synchroniser and filter flops = 1, the bus idle level.
  - Outputs: `kbd_ready`=0, `kbd_data`=0, `kbd_overflow`=0, `frame_err`=0.
  - Reset mid-frame discards the partial frame. FIFO contents are lost.
- Edge latency: a raw `ps2_clk` fall meeting setup at edge k is detected as a fall edge at edge k+2+`FILTER_LEN` (±1 for metastability resolution).
- Push latency: the push happens on the stop-bit fall-edge cycle. `kbd_ready` and `kbd_data` update on the next cycle.
- Pop latency: `kbd_read_enable` high at edge n → the new head (or `kbd_ready`=0) is visible after edge n.
- `frame_err` is high for exactly one cycle per error event.
- Minimum PS/2 clock half-period supported: (`FILTER_LEN`+3) `clk` cycles.

## Test plan
- Frame 0x1C with parity 0 and stop 1 → after the stop bit, `kbd_ready`=1, `kbd_data`=0x1C. One-cycle `kbd_read_enable` → `kbd_ready`=0, `kbd_data`=0.
- Frame 0x1C with parity 1 → one `frame_err` pulse, `kbd_ready` stays 0. Following frame 0xF0 with parity 1 → `kbd_data`=0xF0.
- With `DEPTH`=8, send 0x01..0x09 without reading → `kbd_overflow`=1 after the 9th frame. Eight pops return 0x01..0x08 in order. Overflow clears on the first pop. `kbd_ready`=0 after the 8th pop.
- With the FIFO full, push coincides with a pop → no overflow, count stays 8, the new byte is at the tail.
- Start bit plus 5 data bits, then silence → `frame_err` pulse `TIMEOUT_CYCLES` after the last fall edge, FSM in IDLE. A subsequent 0x5A frame (parity 1) is received correctly.
- Glitch handling: a 2-cycle low glitch on `ps2_clk` mid-frame is ignored and the frame is received intact. Asserting `rst` mid-frame, then sending a full 0x76 frame (parity 0) → only 0x76 appears.
